ifu: RTL

IFU -- requirements
Module: ifu

---
 rtl/ifu_pkg.sv | 23 ++
 rtl/ifu_pc_reg.sv | 24 ++
 rtl/ifu.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, data width
// and the default reset PC, plus a small alignment helper.
// Imported by ifu and pc_reg.
package ifu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Instructions are word aligned; the two low bits of a target must be clear.
  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register with load enable and parameterised reset value.
// Latency: one cycle from load to q. No backpressure; load is obeyed every cycle.
// Ports: clk, rst (sync, active high), load, d (next value), q (current PC).
module pc_reg
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VAL = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: requests the word at pc, holds it for execute until
// commit, then fetches from the committed next_pc. Misaligned targets lock up
// in an error state until reset.
// Latency: request to instruction valid in 2 cycles with a zero-wait memory;
// at most one instruction per 3 cycles.
// Backpressure: request held with a stable address until accepted; the
// instruction is held stable until commit.
// Ports: clk, rst; imem request (valid/ready/addr) and response
// (valid/ready/data); execute side inst_valid/instruction/pc, commit/next_pc;
// status fetch_err (sticky) and inst_count (committed instructions).
module ifu
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  output logic            imem_rsp_ready,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc,
  input  logic            commit,
  input  logic [XLEN-1:0] next_pc,
  output logic            fetch_err,
  output logic [XLEN-1:0] inst_count
);

  state_t state;
  state_t state_nxt;

  // Commit only has meaning while an instruction is presented to execute.
  logic commit_ok;
  logic commit_bad;

  assign commit_ok  = (state == S_VALID) && commit &&  is_aligned(next_pc);
  assign commit_bad = (state == S_VALID) && commit && !is_aligned(next_pc);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ:   if (imem_req_ready) state_nxt = S_WAIT;
      S_WAIT:  if (imem_rsp_valid) state_nxt = S_VALID;
      S_VALID: begin
        if (commit_ok) begin
          state_nxt = S_REQ;
        end else if (commit_bad) begin
          state_nxt = S_ERR;
        end
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state alone, so no input reaches them combinationally.
  always_comb begin
    imem_req_valid = 1'b0;
    imem_rsp_ready = 1'b0;
    inst_valid     = 1'b0;
    case (state)
      S_REQ:   imem_req_valid = 1'b1;
      S_WAIT:  imem_rsp_ready = 1'b1;
      S_VALID: inst_valid     = 1'b1;
      default: ;
    endcase
  end

  // pc only moves on a successful commit, which also keeps the request
  // address stable while a request is outstanding.
  pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (commit_ok),
    .d    (next_pc),
    .q    (pc)
  );

  assign imem_req_addr = pc;

  // Response data is captured only while waiting for it; strays are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= '0;
    end else if ((state == S_WAIT) && imem_rsp_valid) begin
      instruction <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_count <= '0;
    end else if (commit_ok) begin
      inst_count <= inst_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_err <= 1'b0;
    end else if (commit_bad) begin
      fetch_err <= 1'b1;
    end
  end

endmodule
